// File: rtl/tr_track_ctrl.sv
// Closed-loop stepper tracking controller: classifies ADC error into dead/slow/fast zones
// and drives step/dir/enable with direction setup time, fixed pulse width and a position limit.
//
// state | meaning
// IDLE  | motor disabled, waiting for a registered slow/fast zone with tracking enabled
// SETUP | driver enabled, drv_dir loaded, waiting DIR_SETUP cycles before the first step edge
// RUN   | stepping, one pulse per latched period P
// FAULT | position limit reached, everything off until rst
module tr_track_ctrl #(
  parameter int W          = 12,
  parameter int PW         = 16,
  parameter int N_SLOW     = 1000,
  parameter int N_FAST     = 200,
  parameter int PULSE_W    = 10,
  parameter int DIR_SETUP  = 20,
  parameter int CNTW       = 16,
  parameter int STEP_LIMIT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_valid,
  input  logic            tr_mode_enable,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    x0,
  input  logic [W-1:0]    dx1,
  input  logic [W-1:0]    dx2,
  output logic            drv_step,
  output logic            drv_dir,
  output logic            drv_enable_SM,
  output logic            led,
  output logic            fault,
  output logic [PW-1:0]   N,
  output logic [CNTW-1:0] position
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] Z_DEAD = 2'd0;
  localparam logic [1:0] Z_SLOW = 2'd1;
  localparam logic [1:0] Z_FAST = 2'd2;

  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam logic [SW-1:0] SETUP_LD = SW'(DIR_SETUP - 1);
  localparam logic [PW-1:0] PW_HIGH  = PW'(PULSE_W);
  localparam logic [PW-1:0] PW_LAST  = PW'(PULSE_W - 1);

  if (!(PULSE_W >= 1 && PULSE_W < N_FAST && N_FAST <= N_SLOW && (N_SLOW >> PW) == 0 &&
        DIR_SETUP >= 1 && STEP_LIMIT >= 1 && (STEP_LIMIT >> (CNTW - 1)) == 0)) begin : g_bad_params
    $error("tr_track_ctrl: illegal parameter combination");
  end

  logic [1:0]      state;
  logic [1:0]      zone_q;
  logic            tdir_q;
  logic [PW-1:0]   per_cnt;
  logic [PW-1:0]   p_lat;
  logic [SW-1:0]   setup_cnt;
  logic [CNTW-1:0] pos_q;

  logic [W:0]      err;
  logic [W:0]      err_abs;
  logic [1:0]      zone_in;
  logic            tdir_in;
  logic [PW-1:0]   p_next;
  logic [CNTW-1:0] pos_abs;
  logic [CNTW-1:0] pos_step;
  logic            lim;

  assign err     = {1'b0, x} - {1'b0, x0};
  assign err_abs = err[W] ? ({(W+1){1'b0}} - err) : err;
  assign tdir_in = (x > x0);

  // Dead zone is tested first so it wins when dx1 > dx2.
  always_comb begin
    zone_in = Z_FAST;
    if (err_abs <= {1'b0, dx1})      zone_in = Z_DEAD;
    else if (err_abs <= {1'b0, dx2}) zone_in = Z_SLOW;
  end

  assign p_next   = (zone_q == Z_FAST) ? PW'(N_FAST) : PW'(N_SLOW);
  assign pos_abs  = pos_q[CNTW-1] ? ({CNTW{1'b0}} - pos_q) : pos_q;
  assign lim      = ({1'b0, pos_abs} >= (CNTW+1)'(STEP_LIMIT));
  assign pos_step = drv_dir ? (pos_q + CNTW'(1)) : (pos_q - CNTW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      zone_q    <= Z_DEAD;
      tdir_q    <= 1'b0;
      drv_dir   <= 1'b0;
      per_cnt   <= '0;
      p_lat     <= '0;
      setup_cnt <= '0;
      pos_q     <= '0;
    end else begin
      if (data_valid && tr_mode_enable) begin
        zone_q <= zone_in;
        tdir_q <= tdir_in;
      end
      case (state)
        S_IDLE: begin
          if (tr_mode_enable && zone_q != Z_DEAD) begin
            state     <= S_SETUP;
            drv_dir   <= tdir_q;
            setup_cnt <= SETUP_LD;
          end
        end
        S_SETUP: begin
          if (setup_cnt != '0) begin
            setup_cnt <= setup_cnt - SW'(1);
          end else if (!tr_mode_enable || zone_q == Z_DEAD) begin
            state <= S_IDLE;
          end else if (tdir_q != drv_dir) begin
            drv_dir   <= tdir_q;
            setup_cnt <= SETUP_LD;
          end else begin
            state   <= S_RUN;
            per_cnt <= '0;
            p_lat   <= p_next;
            pos_q   <= pos_step;
          end
        end
        S_RUN: begin
          // Fault and enable-drop exits wait for the last high cycle so no pulse is cut short.
          if (lim && per_cnt == PW_LAST) begin
            state <= S_FAULT;
          end else if (!tr_mode_enable && per_cnt >= PW_LAST) begin
            state <= S_IDLE;
          end else if (per_cnt == p_lat - PW'(1)) begin
            if (zone_q == Z_DEAD) begin
              state <= S_IDLE;
            end else if (tdir_q != drv_dir) begin
              state     <= S_SETUP;
              drv_dir   <= tdir_q;
              setup_cnt <= SETUP_LD;
            end else begin
              per_cnt <= '0;
              p_lat   <= p_next;
              pos_q   <= pos_step;
            end
          end else begin
            per_cnt <= per_cnt + PW'(1);
          end
        end
        S_FAULT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign drv_step      = (state == S_RUN) && (per_cnt < PW_HIGH);
  assign drv_enable_SM = (state == S_SETUP) || (state == S_RUN);
  assign fault         = (state == S_FAULT);
  assign N             = (state == S_RUN) ? p_lat : '0;
  assign led           = !rst && tr_mode_enable && (zone_q == Z_DEAD) && (state != S_FAULT);
  assign position      = pos_q;

endmodule

// File: tb/tb_tr_track_ctrl.sv
// Directed bench for tr_track_ctrl: slow/fast stepping, reversal, dead zone, fault limit,
// async reset mid-pulse and enable drop mid-pulse.
module tb_tr_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic        tr_mode_enable;
  logic [11:0] x, x0, dx1, dx2;
  logic        drv_step, drv_dir, drv_enable_SM, led, fault;
  logic [15:0] N;
  logic [15:0] position;

  int total = 0;
  int bad   = 0;

  tr_track_ctrl #(.STEP_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2),
    .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM),
    .led(led), .fault(fault), .N(N), .position(position)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_x(input logic [11:0] v);
    x = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_rise(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!drv_step && c < 3000);
  endtask

  task automatic measure_width(output int w);
    w = 0;
    while (drv_step && w < 100) begin
      w++;
      tick();
    end
  endtask

  task automatic test_reset();
    total++; if (drv_step !== 1'b0) begin bad++; $display("FAIL rst_step: got %b want 0", drv_step); end
    total++; if (drv_dir !== 1'b0) begin bad++; $display("FAIL rst_dir: got %b want 0", drv_dir); end
    total++; if (drv_enable_SM !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", drv_enable_SM); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL rst_led: got %b want 0", led); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
    total++; if (N !== 16'd0) begin bad++; $display("FAIL rst_N: got %0d want 0", N); end
    total++; if (position !== 16'd0) begin bad++; $display("FAIL rst_pos: got %0d want 0", position); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_slow();
    int c, w;
    x0 = 12'd10; dx1 = 12'd55; dx2 = 12'd92; tr_mode_enable = 1'b1;
    sample_x(12'd100);
    tick();
    total++; if (drv_enable_SM !== 1'b1) begin bad++; $display("FAIL slow_setup_en: got %b want 1", drv_enable_SM); end
    total++; if (drv_dir !== 1'b1) begin bad++; $display("FAIL slow_dir: got %b want 1", drv_dir); end
    total++; if (drv_step !== 1'b0 || N !== 16'd0) begin bad++; $display("FAIL slow_setup_idle_out: got step=%b N=%0d want 0 0", drv_step, N); end
    wait_rise(c);
    total++; if (c !== 20) begin bad++; $display("FAIL slow_setup_len: got %0d want 20", c); end
    total++; if (N !== 16'd1000) begin bad++; $display("FAIL slow_N: got %0d want 1000", N); end
    total++; if (position !== 16'd1) begin bad++; $display("FAIL slow_pos1: got %0d want 1", position); end
    measure_width(w);
    total++; if (w !== 10) begin bad++; $display("FAIL slow_width: got %0d want 10", w); end
    wait_rise(c);
    total++; if (c !== 990) begin bad++; $display("FAIL slow_gap: got %0d want 990", c); end
    total++; if (position !== 16'd2) begin bad++; $display("FAIL slow_pos2: got %0d want 2", position); end
  endtask

  task automatic test_fast_switch();
    int c, w;
    repeat (100) tick();
    sample_x(12'd150);
    wait_rise(c);
    total++; if (c !== 899) begin bad++; $display("FAIL fast_period_kept: got %0d want 899", c); end
    total++; if (N !== 16'd200) begin bad++; $display("FAIL fast_N: got %0d want 200", N); end
    total++; if (position !== 16'd3) begin bad++; $display("FAIL fast_pos: got %0d want 3", position); end
    measure_width(w);
    total++; if (w !== 10) begin bad++; $display("FAIL fast_width: got %0d want 10", w); end
  endtask

  task automatic test_reverse();
    int c, w;
    x0 = 12'd200;
    sample_x(12'd100);
    total++; if (drv_dir !== 1'b1) begin bad++; $display("FAIL rev_dir_held: got %b want 1", drv_dir); end
    c = 0;
    do begin tick(); c++; end while (drv_dir !== 1'b0 && c < 3000);
    total++; if (c !== 189) begin bad++; $display("FAIL rev_boundary: got %0d want 189", c); end
    total++; if (drv_step !== 1'b0 || drv_enable_SM !== 1'b1 || N !== 16'd0) begin
      bad++; $display("FAIL rev_setup_out: got step=%b en=%b N=%0d want 0 1 0", drv_step, drv_enable_SM, N); end
    wait_rise(c);
    total++; if (c !== 20) begin bad++; $display("FAIL rev_setup_len: got %0d want 20", c); end
    total++; if (position !== 16'd2 || N !== 16'd200) begin bad++; $display("FAIL rev_pos_N: got pos=%0d N=%0d want 2 200", position, N); end
    measure_width(w);
    wait_rise(c);
    total++; if (c !== 190) begin bad++; $display("FAIL rev_gap: got %0d want 190", c); end
    total++; if (position !== 16'd1) begin bad++; $display("FAIL rev_pos_dec: got %0d want 1", position); end
  endtask

  task automatic test_dead();
    int c;
    x0 = 12'd10;
    sample_x(12'd10);
    c = 0;
    do begin tick(); c++; end while (drv_enable_SM !== 1'b0 && c < 3000);
    total++; if (c !== 199) begin bad++; $display("FAIL dead_boundary: got %0d want 199", c); end
    total++; if (led !== 1'b1) begin bad++; $display("FAIL dead_led: got %b want 1", led); end
    total++; if (N !== 16'd0 || drv_step !== 1'b0 || fault !== 1'b0) begin
      bad++; $display("FAIL dead_out: got N=%0d step=%b fault=%b want 0 0 0", N, drv_step, fault); end
    total++; if (position !== 16'd1) begin bad++; $display("FAIL dead_pos: got %0d want 1", position); end
    tr_mode_enable = 1'b0;
    #1;
    total++; if (led !== 1'b0) begin bad++; $display("FAIL dead_led_off: got %b want 0", led); end
  endtask

  task automatic test_fault();
    int c, pulses;
    logic prev;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (position !== 16'd0 || fault !== 1'b0) begin bad++; $display("FAIL flt_pre: got pos=%0d fault=%b want 0 0", position, fault); end
    tr_mode_enable = 1'b1; x0 = 12'd10;
    sample_x(12'd150);
    pulses = 0; prev = 1'b0; c = 0;
    do begin
      tick(); c++;
      if (drv_step && !prev) pulses++;
      prev = drv_step;
    end while (!fault && c < 5000);
    total++; if (pulses !== 4) begin bad++; $display("FAIL flt_pulses: got %0d want 4", pulses); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL flt_flag: got %b want 1", fault); end
    total++; if (drv_step !== 1'b0 || drv_enable_SM !== 1'b0 || N !== 16'd0) begin
      bad++; $display("FAIL flt_out: got step=%b en=%b N=%0d want 0 0 0", drv_step, drv_enable_SM, N); end
    total++; if (position !== 16'd4) begin bad++; $display("FAIL flt_pos: got %0d want 4", position); end
    sample_x(12'd100);
    repeat (50) tick();
    total++; if (fault !== 1'b1 || drv_enable_SM !== 1'b0 || drv_step !== 1'b0) begin
      bad++; $display("FAIL flt_sticky: got fault=%b en=%b step=%b want 1 0 0", fault, drv_enable_SM, drv_step); end
    rst = 1'b1; tick();
    total++; if (fault !== 1'b0 || position !== 16'd0 || N !== 16'd0 || drv_dir !== 1'b0 || led !== 1'b0) begin
      bad++; $display("FAIL flt_reset: got fault=%b pos=%0d N=%0d dir=%b led=%b want all 0", fault, position, N, drv_dir, led); end
    tr_mode_enable = 1'b0;
    rst = 1'b0; tick();
  endtask

  task automatic test_reset_mid_pulse();
    int c;
    tr_mode_enable = 1'b1; x0 = 12'd10;
    sample_x(12'd150);
    wait_rise(c);
    total++; if (c !== 21) begin bad++; $display("FAIL rmp_rise: got %0d want 21", c); end
    repeat (3) tick();
    total++; if (drv_step !== 1'b1) begin bad++; $display("FAIL rmp_high: got %b want 1", drv_step); end
    #2 rst = 1'b1;
    #1;
    total++; if (drv_step !== 1'b0 || drv_enable_SM !== 1'b0 || position !== 16'd0) begin
      bad++; $display("FAIL rmp_async: got step=%b en=%b pos=%0d want 0 0 0", drv_step, drv_enable_SM, position); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int c, w;
    sample_x(12'd150);
    wait_rise(c);
    total++; if (c !== 21) begin bad++; $display("FAIL edrop_rise: got %0d want 21", c); end
    repeat (3) tick();
    tr_mode_enable = 1'b0;
    measure_width(w);
    total++; if (w !== 7) begin bad++; $display("FAIL edrop_rest_width: got %0d want 7", w); end
    total++; if (drv_enable_SM !== 1'b0 || N !== 16'd0) begin
      bad++; $display("FAIL edrop_idle: got en=%b N=%0d want 0 0", drv_enable_SM, N); end
    total++; if (position !== 16'd1) begin bad++; $display("FAIL edrop_pos: got %0d want 1", position); end
    repeat (30) tick();
    total++; if (drv_enable_SM !== 1'b0 || drv_step !== 1'b0) begin
      bad++; $display("FAIL edrop_stays: got en=%b step=%b want 0 0", drv_enable_SM, drv_step); end
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; tr_mode_enable = 1'b0;
    x = '0; x0 = '0; dx1 = 12'd55; dx2 = 12'd92;
    repeat (3) tick();
    test_reset();
    test_slow();
    test_fast_switch();
    test_reverse();
    test_dead();
    test_fault();
    test_reset_mid_pulse();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tr_track_ctrl.md
TR_TRACK_CTRL -- requirements
Module: tr_track_ctrl

Interface
REQ-001 Parameter W, default 12, ADC sample and threshold width.
REQ-002 Parameter PW, default 16, step-period counter width.
REQ-003 Parameter N_SLOW, default 1000, step period in clk cycles for the slow zone.
REQ-004 Parameter N_FAST, default 200, step period in clk cycles for the fast zone.
REQ-005 Parameter PULSE_W, default 10, drv_step high time in clk cycles.
REQ-006 Parameter DIR_SETUP, default 20, clk cycles from a drv_dir change to the next step edge.
REQ-007 Parameter CNTW, default 16, position counter width; STEP_LIMIT, default 4096, fault threshold on |position|.
REQ-008 The block SHALL use one clock and an asynchronous, active-high reset, on these ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-high reset.
- data_valid  in  1  qualifies x for one clk cycle.
- tr_mode_enable  in  1  tracking permit.
- x  in  W  ADC sample, unsigned.
- x0  in  W  target value, unsigned.
- dx1  in  W  dead-zone half-width.
- dx2  in  W  slow/fast boundary.
- drv_step  out  1  stepper step pulse.
- drv_dir  out  1  direction; 1 when x > x0.
- drv_enable_SM  out  1  motor driver enable.
- led  out  1  on-target indicator.
- fault  out  1  position limit reached.
- N  out  PW  active step period; 0 when not stepping.
- position  out  CNTW  signed net step count.

Function
REQ-009 Parameters SHALL satisfy PULSE_W < N_FAST <= N_SLOW < 2^PW; the implementation SHALL flag a violation at elaboration.
REQ-010 Error SHALL be e = x - x0, computed in W+1 signed bits; |e| SHALL be computed in W+1 bits without overflow.
REQ-011 Zone SHALL be classified as follows, with DEAD taking priority if dx1 > dx2:
- DEAD: |e| <= dx1.
- SLOW: dx1 < |e| <= dx2.
- FAST: |e| > dx2.
REQ-012 Sampling SHALL occur only on a clk edge with data_valid=1 and tr_mode_enable=1; zone and target direction SHALL be registered one cycle later and held until the next qualified sample.
REQ-013 The FSM SHALL have four states: IDLE, SETUP, RUN, FAULT.
REQ-014 IDLE -> SETUP SHALL occur when the registered zone is SLOW or FAST and tr_mode_enable=1.
REQ-015 On SETUP entry, drv_dir SHALL load the target direction and drv_enable_SM SHALL go 1; after DIR_SETUP cycles the FSM SHALL go to RUN.
REQ-016 In RUN, a period counter SHALL count 0..P-1, where P is N_SLOW or N_FAST; drv_step SHALL be 1 while the count is < PULSE_W.
REQ-017 P SHALL be latched at count 0; a zone change SHALL take effect only at the next period boundary, never truncating a period.
REQ-018 At each period boundary in RUN, the FSM SHALL act as follows:
- DEAD zone or tr_mode_enable=0 -> IDLE.
- Target direction differs from drv_dir -> SETUP.
- Otherwise -> start the next period.
REQ-019 If tr_mode_enable falls mid-period, the FSM SHALL go to IDLE when the count reaches PULSE_W, or immediately if the count is already >= PULSE_W; drv_step SHALL never be shorter than PULSE_W.
REQ-020 Position SHALL change by +1 (drv_dir=1) or -1 at each drv_step rising edge, with wrap-free signed arithmetic.
REQ-021 When |position| reaches STEP_LIMIT, the FSM SHALL go to FAULT after the current pulse high phase ends.
REQ-022 In FAULT: fault=1, drv_step=0, drv_enable_SM=0, N=0; FAULT SHALL be exited only by rst.
REQ-023 drv_enable_SM SHALL be 1 exactly in SETUP and RUN.
REQ-024 N SHALL equal the latched P in RUN and 0 otherwise.
REQ-025 led SHALL be 1 when tr_mode_enable=1, the registered zone is DEAD and the state is not FAULT.
REQ-026 A qualified sample arriving in the same cycle as a period boundary SHALL have its registered zone used at the following boundary, not the current one.

Reset
REQ-027 While rst=1, the block SHALL asynchronously set: state IDLE, drv_step=0, drv_dir=0, drv_enable_SM=0, led=0, fault=0, N=0, position=0, all counters 0, registered zone DEAD.
REQ-028 Reset asserted mid-pulse SHALL drop drv_step the same instant.
REQ-029 After rst deasserts, the first clk edge SHALL be a normal operating edge.

Verification
REQ-030 Default parameters, x0=10, dx1=55, dx2=92; samples x=100 (e=90) -> SETUP for 20 cycles, drv_dir=1, then RUN with N=1000, 10-cycle pulses every 1000 cycles, position incrementing.
REQ-031 Switch x to 150 (e=140) mid-period -> current 1000-cycle period completes, then N=200 with no runt pulse.
REQ-032 x0=200, x=100 (e=-100) while running forward -> finish period, SETUP, drv_dir=0, 20-cycle gap, then position decrements at N=200.
REQ-033 x=10 (e=0) -> IDLE at the period boundary, led=1, drv_enable_SM=0, N=0; drop tr_mode_enable -> led=0.
REQ-034 STEP_LIMIT=4, FAST zone -> after the 4th pulse fault=1 and stepping stops; new samples are ignored until rst, after which all outputs equal their reset values.
REQ-035 Assert rst during drv_step high -> drv_step=0 without waiting for clk; drop tr_mode_enable at pulse count 3 -> pulse stays high until count 10, then IDLE.
